uart_slave: RTL and testbench
=============================

UART_SLAVE -- requirements
Module: uart_slave

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16'd434, reset value of the baud divisor (50 MHz / 115200).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port slave_addr  input  8  byte address; bit 0 ignored.
REQ-005 SHALL have port slave_write  input  16  write data from the bus master.
REQ-006 SHALL have port slave_read  output  16  read data to the bus master.
REQ-007 SHALL have port slave_uds  input  1  upper-byte strobe, active-high.
REQ-008 SHALL have port slave_lds  input  1  lower-byte strobe, active-high.
REQ-009 SHALL have port slave_we  input  1  1 = write access, 0 = read access; valid while a strobe is high.
REQ-010 SHALL have port slave_ack  output  1  access-complete acknowledge.
REQ-011 SHALL have port uart_tx  output  1  serial transmit line, idle high.
REQ-012 SHALL have port uart_rx  input  1  serial receive line, asynchronous to clk.

Function
REQ-013 SHALL define an access as the interval during which slave_uds|slave_lds is high.
REQ-014 SHALL raise slave_ack on the first clk edge that samples an access (1-cycle latency), hold it while the access lasts, and drop it on the first edge that samples both strobes low.
REQ-015 SHALL perform register side effects exactly once per access, on the edge that raises slave_ack.
REQ-016 SHALL drive slave_read with the addressed register while slave_ack is high and 16'h0000 otherwise.
REQ-017 SHALL map 0x00 DATA: write with lds pushes slave_write[7:0] into TX FIFO, uds-only write ignored; read returns {8'h00, rx_data} and clears rx_valid.
REQ-018 SHALL map 0x02 STATUS, read bits: 0 rx_valid, 1 rx_overrun, 2 tx_full, 3 tx_empty, 4 tx_busy, 5 tx_overflow, 6 rx_frame_err, others 0; write with lds: each 1 in bits 1, 5, 6 clears that sticky flag.
REQ-019 SHALL map 0x04 BAUDDIV: read returns divisor; write updates [15:8] under uds and [7:0] under lds; values below 16 are used as 16.
REQ-020 SHALL acknowledge all other addresses, reading 0 and ignoring writes.
REQ-021 SHALL provide a 4-entry TX FIFO; push when full discards data and sets tx_overflow, unless the transmitter pops in the same cycle, in which case the push is accepted.
REQ-022 SHALL transmit 8N1 LSB first, each bit lasting exactly BAUDDIV clk cycles, via TX states IDLE -> START -> DATA(8 bits) -> STOP -> IDLE, or STOP -> START directly when the FIFO is non-empty.
REQ-023 SHALL assert tx_busy in all TX states other than IDLE; the divisor is sampled at each START.
REQ-024 SHALL synchronise uart_rx through two flip-flops before use.
REQ-025 SHALL use RX states IDLE -> START on a synchronised falling edge; sample at BAUDDIV/2 cycles, returning to IDLE if high (glitch); otherwise DATA samples every BAUDDIV cycles for 8 bits, then STOP.
REQ-026 SHALL on a low stop bit discard the byte and set rx_frame_err; on a high stop bit load rx_data and set rx_valid.
REQ-027 SHALL set rx_overrun and overwrite rx_data when a byte completes while rx_valid is 1, except when a DATA read clears rx_valid in that same cycle, in which case the new byte is loaded with rx_valid=1 and no overrun.

Reset
REQ-028 SHALL on reset_n low immediately set slave_ack=0, slave_read=0, uart_tx=1, FIFO empty, all flags 0, rx_data=0, BAUDDIV=DEFAULT_DIV, both FSMs IDLE, including mid-frame and mid-access.
REQ-029 SHALL after reset release ignore any strobe already high until it has been sampled low once.

Verification
REQ-030 SHALL cover: BAUDDIV=16, write 0x00 = 16'h00A5 with lds -> uart_tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles.
REQ-031 SHALL cover: five DATA writes back-to-back while idle -> four bytes sent in order, fifth dropped, STATUS bit5=1; write STATUS 0x0020 -> bit5=0.
REQ-032 SHALL cover: drive uart_rx with 0x3C frame at 16 cycles/bit -> STATUS=0x0009; read DATA -> 16'h003C, then STATUS=0x0008.
REQ-033 SHALL cover: two RX frames 0x11, 0x22 without reading -> DATA reads 0x0022, STATUS bit1=1; frame with low stop bit -> bit6=1, rx_valid unchanged.
REQ-034 SHALL cover: access held 5 cycles -> ack high cycles 2-6, one FIFO push only; uds-only write of 16'h1200 to 0x04 -> BAUDDIV=16'h12xx, lower byte unchanged.
REQ-035 SHALL cover: reset_n pulsed low mid-TX-byte -> uart_tx=1 in the same cycle, STATUS reads 0x0008 afterwards.

Source files
------------

// File: rtl/uart_slave.sv
// UART peripheral on a 16-bit strobed slave bus: DATA, STATUS and BAUDDIV registers,
// a 4-entry transmit FIFO, and 8N1 transmit/receive engines sharing one baud divisor.
module uart_slave #(
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  slave_addr,
  input  logic [15:0] slave_write,
  output logic [15:0] slave_read,
  input  logic        slave_uds,
  input  logic        slave_lds,
  input  logic        slave_we,
  output logic        slave_ack,
  output logic        uart_tx,
  input  logic        uart_rx
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic        armed_q, ack_q;
  logic [15:0] rd_q;
  logic [15:0] div_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, rx_ovr_q, tx_ovf_q, rx_ferr_q;

  logic [7:0]  fifo_mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  fifo_cnt_q;

  tx_state_e   tx_state_q;
  logic        tx_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0]  tx_bit_q;
  logic [6:0]  tx_sh_q;

  rx_state_e   rx_state_q;
  logic        rx_m_q, rx_s_q, rx_p_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  logic        strobe_s, acc_s, wr_s, rd_s;
  logic [1:0]  sel_s;
  logic        push_req_s, push_ok_s, pop_s, ovf_set_s, data_rd_s, stat_wr_s;
  logic        full_s, empty_s, tx_end_s, rx_half_s, rx_end_s, rx_stop_s;
  logic        rx_done_s, rx_ferr_s;
  logic [15:0] eff_div_s, status_s, rdata_s;

  assign slave_ack  = ack_q;
  assign slave_read = rd_q;
  assign uart_tx    = tx_q;

  // An access is taken on the first sampled edge only; strobes held through reset are ignored.
  assign strobe_s  = slave_uds | slave_lds;
  assign acc_s     = armed_q & strobe_s & ~ack_q;
  assign wr_s      = acc_s & slave_we;
  assign rd_s      = acc_s & ~slave_we;

  // Register decode on the full byte address so that odd addresses alias the even register.
  always_comb begin
    case (slave_addr)
      8'h00, 8'h01: sel_s = 2'd1;
      8'h02, 8'h03: sel_s = 2'd2;
      8'h04, 8'h05: sel_s = 2'd3;
      default:      sel_s = 2'd0;
    endcase
  end

  assign push_req_s = wr_s & (sel_s == 2'd1) & slave_lds;
  assign data_rd_s  = rd_s & (sel_s == 2'd1);
  assign stat_wr_s  = wr_s & (sel_s == 2'd2) & slave_lds;

  assign eff_div_s  = (div_q < 16'd16) ? 16'd16 : div_q;
  assign full_s     = (fifo_cnt_q == 3'd4);
  assign empty_s    = (fifo_cnt_q == 3'd0);
  assign tx_end_s   = (tx_cnt_q == tx_div_q - 16'd1);
  // The head byte stays in the FIFO while it is on the wire and is popped at the end of its stop bit.
  assign pop_s      = (tx_state_q == TX_STOP) & tx_end_s;
  assign push_ok_s  = push_req_s & (~full_s | pop_s);
  assign ovf_set_s  = push_req_s & full_s & ~pop_s;

  assign rx_half_s  = (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1);
  assign rx_end_s   = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_stop_s  = (rx_state_q == RX_STOP) & rx_end_s;
  assign rx_done_s  = rx_stop_s & rx_s_q;
  assign rx_ferr_s  = rx_stop_s & ~rx_s_q;

  assign status_s = {9'd0, rx_ferr_q, tx_ovf_q, (tx_state_q != TX_IDLE), empty_s, full_s,
                     rx_ovr_q, rx_valid_q};

  // Read data mux for the addressed register.
  always_comb begin
    case (sel_s)
      2'd1:    rdata_s = {8'h00, rx_data_q};
      2'd2:    rdata_s = status_s;
      2'd3:    rdata_s = div_q;
      default: rdata_s = 16'h0000;
    endcase
  end

  // Bus handshake: acknowledge, read data capture and post-reset strobe arming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
      rd_q    <= 16'h0000;
    end else begin
      armed_q <= armed_q | ~strobe_s;
      ack_q   <= armed_q & strobe_s;
      if (!(armed_q & strobe_s)) begin
        rd_q <= 16'h0000;
      end else if (acc_s) begin
        rd_q <= rdata_s;
      end
    end
  end

  // Control registers and sticky flags; a flag being set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= DEFAULT_DIV;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      if (wr_s && sel_s == 2'd3 && slave_uds) div_q[15:8] <= slave_write[15:8];
      if (wr_s && sel_s == 2'd3 && slave_lds) div_q[7:0]  <= slave_write[7:0];
      if (ovf_set_s) tx_ovf_q <= 1'b1;
      else if (stat_wr_s && slave_write[5]) tx_ovf_q <= 1'b0;
      if (rx_ferr_s) rx_ferr_q <= 1'b1;
      else if (stat_wr_s && slave_write[6]) rx_ferr_q <= 1'b0;
      if (rx_done_s && rx_valid_q && !data_rd_s) rx_ovr_q <= 1'b1;
      else if (stat_wr_s && slave_write[1]) rx_ovr_q <= 1'b0;
      if (rx_done_s) begin
        rx_data_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end else if (data_rd_s) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // Transmit FIFO storage and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= 8'h00;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
    end else begin
      if (push_ok_s) begin
        fifo_mem_q[wr_ptr_q] <= slave_write[7:0];
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + 2'd1;
      fifo_cnt_q <= fifo_cnt_q + {2'b00, push_ok_s} - {2'b00, pop_s};
    end
  end

  // Transmit FSM; the divisor is latched at each start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'd16;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 7'd0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q     <= 1'b1;
          tx_cnt_q <= 16'd0;
          if (!empty_s) begin
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_div_q   <= eff_div_s;
          end
        end
        TX_START: begin
          if (tx_end_s) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_q       <= fifo_mem_q[rd_ptr_q][0];
            tx_sh_q    <= fifo_mem_q[rd_ptr_q][7:1];
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_end_s) begin
            tx_cnt_q <= 16'd0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[6:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_end_s) begin
            tx_cnt_q <= 16'd0;
            if (fifo_cnt_q > 3'd1 || push_ok_s) begin
              tx_state_q <= TX_START;
              tx_q       <= 1'b0;
              tx_div_q   <= eff_div_s;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  // Receive synchroniser and FSM; the extra stage rx_p_q provides falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_p_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= 16'd16;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
    end else begin
      rx_m_q <= uart_rx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= 16'd0;
          if (rx_p_q && !rx_s_q) begin
            rx_state_q <= RX_START;
            rx_div_q   <= eff_div_s;
          end
        end
        RX_START: begin
          if (rx_half_s) begin
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_end_s) begin
            rx_cnt_q <= 16'd0;
            rx_sh_q  <= {rx_s_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_end_s) begin
            rx_cnt_q   <= 16'd0;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_slave.sv
// Self-checking bench for uart_slave: bus register accesses, a TX line monitor fed by a
// scoreboard queue, an RX frame driver, and reset behaviour.
module tb_uart_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  slave_addr;
  logic [15:0] slave_write;
  logic [15:0] slave_read;
  logic        slave_uds, slave_lds, slave_we, slave_ack;
  logic        uart_tx, uart_rx;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_div  = 16;
  logic [7:0]  tx_sb_q [$];
  logic [15:0] r;

  always #5 clk = ~clk;

  uart_slave #(.DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .reset_n(reset_n), .slave_addr(slave_addr), .slave_write(slave_write),
    .slave_read(slave_read), .slave_uds(slave_uds), .slave_lds(slave_lds),
    .slave_we(slave_we), .slave_ack(slave_ack), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One bus access holding the strobes for 'hold' sampled edges.
  task automatic bus(input logic [7:0] a, input logic [15:0] wd, input logic u, input logic l,
                     input logic we, input int hold, output logic [15:0] rd);
    rd = 16'hxxxx;
    @(negedge clk);
    slave_addr = a; slave_write = wd; slave_uds = u; slave_lds = l; slave_we = we;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) rd = slave_read;
      check_eq("ack_high", slave_ack, 1);
    end
    slave_uds = 1'b0; slave_lds = 1'b0; slave_we = 1'b0;
    @(negedge clk);
    check_eq("ack_low", slave_ack, 0);
    check_eq("read_idle", slave_read, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] wd, input logic u, input logic l);
    logic [15:0] d;
    bus(a, wd, u, l, 1'b1, 1, d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus(a, 16'h0000, 1'b0, 1'b1, 1'b0, 1, d);
    check_eq(tag, d, exp);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_sb_q.push_back(b);
    wr(8'h00, {8'h00, b}, 1'b0, 1'b1);
  endtask

  task automatic wait_tx_idle();
    logic [15:0] d;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1500 && !done; i++) begin
      bus(8'h02, 16'h0000, 1'b0, 1'b1, 1'b0, 1, d);
      if (d[4] == 1'b0 && d[3] == 1'b1) done = 1'b1;
    end
    check_eq("tx_idle_reached", done, 1);
    check_eq("tx_sb_drained", tx_sb_q.size(), 0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rx = f[k];
      repeat (cur_div - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * cur_div) @(negedge clk);
  endtask

  // TX monitor: checks the first and last cycle of every bit against the scoreboard byte.
  initial begin : tx_mon
    logic       prev;
    logic [9:0] frame;
    logic [7:0] exp_b;
    int         dv;
    bit         abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && prev === 1'b1 && uart_tx === 1'b0) begin
        check_eq("tx_frame_expected", (tx_sb_q.size() != 0), 1);
        exp_b = (tx_sb_q.size() != 0) ? tx_sb_q.pop_front() : 8'hFF;
        frame = {1'b1, exp_b, 1'b0};
        dv = cur_div;
        abort = 1'b0;
        for (int n = 0; n < 10 * dv && !abort; n++) begin
          if (n > 0) @(negedge clk);
          if (reset_n !== 1'b1) abort = 1'b1;
          else if ((n % dv) == 0 || (n % dv) == dv - 1)
            check_eq($sformatf("tx_byte%02h_bit%0d", exp_b, n / dv), uart_tx, frame[n / dv]);
        end
      end
      prev = uart_tx;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; slave_addr = 8'h00; slave_write = 16'h0000;
    slave_uds = 1'b0; slave_lds = 1'b0; slave_we = 1'b0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_ack", slave_ack, 0);
    check_eq("reset_read", slave_read, 0);
    check_eq("reset_tx", uart_tx, 1);

    // Strobe already high at reset release must be ignored until seen low.
    slave_addr = 8'h02; slave_lds = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stale_strobe_ignored", slave_ack, 0);
    slave_lds = 1'b0;
    @(negedge clk);

    rd_chk("bauddiv_reset", 8'h04, 16'h01B2);
    rd_chk("status_reset", 8'h02, 16'h0008);

    wr(8'h04, 16'h0010, 1'b1, 1'b1);
    cur_div = 16;
    rd_chk("bauddiv_16", 8'h04, 16'h0010);
    push_tx(8'hA5);
    wait_tx_idle();

    wr(8'h00, 16'h0077, 1'b1, 1'b0);
    rd_chk("uds_only_data_ignored", 8'h02, 16'h0008);

    for (int k = 0; k < 5; k++) begin
      if (k < 4) tx_sb_q.push_back(8'hC1 + 8'(k));
      wr(8'h00, {8'h00, 8'hC1 + 8'(k)}, 1'b0, 1'b1);
    end
    rd_chk("status_overflow", 8'h02, 16'h0034);
    wr(8'h02, 16'h0020, 1'b0, 1'b1);
    rd_chk("status_ovf_cleared", 8'h02, 16'h0014);
    wait_tx_idle();

    // Divisor below 16 reads back as written but runs at 16; held access pushes once.
    wr(8'h04, 16'h0005, 1'b1, 1'b1);
    rd_chk("bauddiv_5", 8'h04, 16'h0005);
    tx_sb_q.push_back(8'h5A);
    bus(8'h00, 16'h005A, 1'b0, 1'b1, 1'b1, 5, r);
    wait_tx_idle();
    rd_chk("status_after_held", 8'h02, 16'h0008);

    wr(8'h04, 16'h1200, 1'b1, 1'b0);
    rd_chk("bauddiv_upper_only", 8'h04, 16'h1205);
    wr(8'h04, 16'h0010, 1'b1, 1'b1);

    wr(8'h06, 16'hFFFF, 1'b1, 1'b1);
    rd_chk("unmapped_06", 8'h06, 16'h0000);
    rd_chk("unmapped_80", 8'h80, 16'h0000);
    rd_chk("odd_addr_status", 8'h03, 16'h0008);

    rx_frame(8'h3C, 1'b1);
    rd_chk("rx_status_valid", 8'h02, 16'h0009);
    rd_chk("rx_data_3c", 8'h00, 16'h003C);
    rd_chk("rx_status_cleared", 8'h02, 16'h0008);

    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    rd_chk("rx_status_overrun", 8'h02, 16'h000B);
    rx_frame(8'h55, 1'b0);
    rd_chk("rx_status_frame_err", 8'h02, 16'h004B);
    rd_chk("rx_data_22", 8'h00, 16'h0022);
    rd_chk("rx_status_after_read", 8'h02, 16'h004A);
    wr(8'h02, 16'h0042, 1'b0, 1'b1);
    rd_chk("rx_status_flags_cleared", 8'h02, 16'h0008);

    @(negedge clk); uart_rx = 1'b0;
    repeat (3) @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    rd_chk("rx_glitch_ignored", 8'h02, 16'h0008);

    // Reset in the middle of a byte of zeros: line must return high immediately.
    push_tx(8'h00);
    repeat (60) @(negedge clk);
    check_eq("tx_low_mid_byte", uart_tx, 0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset_async_tx", uart_tx, 1);
    check_eq("reset_async_ack", slave_ack, 0);
    repeat (2) @(negedge clk);
    tx_sb_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    rd_chk("status_after_reset", 8'h02, 16'h0008);
    rd_chk("bauddiv_after_reset", 8'h04, 16'h01B2);
    check_eq("tx_idle_after_reset", uart_tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
